// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl -- MIPS Coprocessor-0 for the M stage of the 5-stage core.
//
// Holds SR (12), Cause (13), EPC (14) and PRId (15), plus the optional
// Count (9) / Compare (11) timer. It raises int_req for an enabled external
// or timer interrupt, or for a pending M-stage exception, and
// captures BD/ExcCode/EPC on the following edge.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   -> Count/Compare registers and timer interrupt ti on Cause.IP[15]
//   undefined -> regs 9/11 read 0, writes ignored, ti tied low
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   a1       mfc0 read register number
//   a2       mtc0 write register number
//   din      mtc0 write data
//   we       mtc0 write enable
//   dout     combinational read data for a1
//   pc       M-stage instruction PC
//   bd       M-stage instruction is in a delay slot
//   exccode  merged M-stage exception code (0 = none)
//   hwint    level-sensitive external interrupt lines
//   exl_clr  eret in M stage
//   int_req  take exception/interrupt this cycle
//   epc      EPC register value
//   vec_pc   handler entry address (constant EXC_VEC)

module cp0_irq_ctrl #(
    parameter int unsigned NUM_HWINT = 6,
    parameter logic [31:0] PRID      = 32'h2025_0007,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           a1,
    input  logic [4:0]           a2,
    input  logic [31:0]          din,
    input  logic                 we,
    output logic [31:0]          dout,
    input  logic [31:0]          pc,
    input  logic                 bd,
    input  logic [4:0]           exccode,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 exl_clr,
    output logic                 int_req,
    output logic [31:0]          epc,
    output logic [31:0]          vec_pc
);

    logic [7:0]  sr_im;        // SR[15:8]
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [5:0]  ip_r;         // registered hwint, Cause[15:10]
    logic [31:0] epc_r;

    logic [5:0]  hw_ext;
    logic [5:0]  ip_eff;
    logic        ti;
    logic        irq;
    logic        exc;
    logic        wr_en;
    logic [31:0] epc_exc;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;

    // Zero-extend the external lines to the full 6-bit IP field.
    always_comb begin
        hw_ext = '0;
        hw_ext[NUM_HWINT-1:0] = hwint;
    end

    assign ip_eff  = ip_r | {ti, 5'b0_0000};
    assign irq     = sr_ie & ~sr_exl & (|(ip_eff & sr_im[7:2]));
    assign exc     = (exccode != 5'd0) & ~sr_exl;
    assign int_req = irq | exc;
    // A trapping instruction must not commit its own mtc0.
    assign wr_en   = we & ~int_req;
    assign epc_exc = (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            ip_r      <= '0;
            epc_r     <= '0;
        end else begin
            ip_r <= hw_ext;
            if (int_req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd;
                cause_exc <= irq ? 5'd0 : exccode;
                epc_r     <= epc_exc;
            end else begin
                if (wr_en && a2 == 5'd12) begin
                    sr_im  <= din[15:8];
                    sr_exl <= din[1];
                    sr_ie  <= din[0];
                end
                if (wr_en && a2 == 5'd14) begin
                    epc_r <= din & 32'hFFFF_FFFC;
                end
                if (exl_clr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic [31:0] count_nxt;

    assign count_nxt = (wr_en && a2 == 5'd9) ? din : count_r + 32'd1;

    // ti compares against the post-edge Count; a Compare write clears it and
    // takes precedence over a match in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r   <= '0;
            compare_r <= '1;
            ti        <= 1'b0;
        end else begin
            count_r <= count_nxt;
            if (wr_en && a2 == 5'd11) begin
                compare_r <= din;
                ti        <= 1'b0;
            end else if (count_nxt == compare_r) begin
                ti <= 1'b1;
            end
        end
    end

    assign count_rd   = count_r;
    assign compare_rd = compare_r;
`else
    assign ti         = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    always_comb begin
        dout = '0;
        case (a1)
            5'd9:    dout = count_rd;
            5'd11:   dout = compare_rd;
            5'd12:   dout = {16'b0, sr_im, 6'b0, sr_exl, sr_ie};
            5'd13:   dout = {cause_bd, 15'b0, ip_eff, 3'b0, cause_exc, 2'b0};
            5'd14:   dout = epc_r;
            5'd15:   dout = PRID;
            default: dout = '0;
        endcase
    end

    assign epc    = epc_r;
    assign vec_pc = EXC_VEC;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Self-checking bench for cp0_irq_ctrl: directed literal checks followed by
// randomized traffic compared every cycle against a word-level model.
module tb_cp0_irq_ctrl;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] dout;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exccode;
    logic [5:0]  hwint;
    logic        exl_clr;
    logic        int_req;
    logic [31:0] epc;
    logic [31:0] vec_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_irq_ctrl #(
        .NUM_HWINT(6),
        .PRID(32'h2025_0007),
        .EXC_VEC(32'h0000_4180)
    ) dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
        .dout(dout), .pc(pc), .bd(bd), .exccode(exccode), .hwint(hwint),
        .exl_clr(exl_clr), .int_req(int_req), .epc(epc), .vec_pc(vec_pc)
    );

    // Model state: whole register words as software would see them.
    logic [31:0] m_sr, m_epc, m_count, m_cmp;
    logic        m_bd, m_ti;
    logic [4:0]  m_exc;
    logic [5:0]  m_ip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr = 0; m_epc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
        m_bd = 0; m_ti = 0; m_exc = 0; m_ip = 0;
    endtask

    function automatic logic [5:0] m_ipe();
        return m_ip | (m_ti ? 6'b10_0000 : 6'b0);
    endfunction

    function automatic bit m_irq();
        bit ie  = m_sr[0];
        bit exl = m_sr[1];
        logic [5:0] im = m_sr[15:10];
        return ie && !exl && ((m_ipe() & im) != 6'd0);
    endfunction

    function automatic bit m_int();
        return m_irq() || (exccode != 5'd0 && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        case (r)
            5'd9:    return TIMER ? m_count : 32'd0;
            5'd11:   return TIMER ? m_cmp : 32'd0;
            5'd12:   return m_sr;
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ipe()) << 10) | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            5'd15:   return 32'h2025_0007;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit          take = m_int();
        bit          irq  = m_irq();
        bit          wr   = we && !take;
        logic [31:0] new_count = (wr && a2 == 5'd9) ? din : m_count + 32'd1;
        if (take) begin
            m_sr  = m_sr | 32'd2;
            m_bd  = bd;
            m_exc = irq ? 5'd0 : exccode;
            m_epc = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
        end else begin
            if (wr && a2 == 5'd12) m_sr = din & 32'h0000_FF03;
            if (wr && a2 == 5'd14) m_epc = din & 32'hFFFF_FFFC;
            if (exl_clr) m_sr = m_sr & ~32'd2;
        end
        if (wr && a2 == 5'd11) begin
            m_cmp = din;
            m_ti  = 1'b0;
        end else if (TIMER && new_count == m_cmp) begin
            m_ti = 1'b1;
        end
        m_count = new_count;
        m_ip    = hwint;
    endtask

    // Compare process: outputs are checked mid-cycle, then the model advances
    // with the inputs the DUT will sample on the coming rising edge.
    always @(negedge clk) begin
        if (!reset) model_reset();
        check("int_req", {31'd0, int_req}, {31'd0, m_int()});
        check("dout", dout, m_read(a1));
        check("epc", epc, m_epc);
        check("vec_pc", vec_pc, 32'h0000_4180);
        if (reset) model_step();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] v);
        we = 1'b1; a2 = r; din = v;
        cyc();
        we = 1'b0;
    endtask

    logic [4:0] regs [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd20};

    initial begin
        model_reset();
        reset = 0; a1 = 5'd12; a2 = 0; din = 0; we = 0; pc = 32'h3000; bd = 0;
        exccode = 0; hwint = 0; exl_clr = 0;
        #3;
        check("rst_sr", dout, 32'h0);
        check("rst_int", {31'd0, int_req}, 32'h0);
        check("rst_epc", epc, 32'h0);
        a1 = 5'd11; #1;
        check("rst_cmp", dout, TIMER ? 32'hFFFF_FFFF : 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        a1 = 5'd12;

        // Enabled external interrupt, one cycle of sampling latency.
        mtc0(5'd12, 32'h0000_0401);
        check("sr_write", dout, 32'h0000_0401);
        hwint = 6'b00_0001; pc = 32'h3010; bd = 0;
        #1 check("irq_latency", {31'd0, int_req}, 32'h0);
        cyc();
        check("irq_req", {31'd0, int_req}, 32'h1);
        cyc();
        check("irq_epc", epc, 32'h3010);
        a1 = 5'd13; #1;
        check("irq_cause", dout, 32'h0000_0400);
        check("irq_exl_mask", {31'd0, int_req}, 32'h0);
        a1 = 5'd12; #1;
        check("irq_sr", dout, 32'h0000_0403);
        exccode = 5'd10; #1;
        check("exl_masks_exc", {31'd0, int_req}, 32'h0);
        exccode = 0; hwint = 0;
        exl_clr = 1; cyc(); exl_clr = 0;
        check("eret_sr", dout, 32'h0000_0401);
        check("eret_int", {31'd0, int_req}, 32'h0);

        // Exception in a delay slot.
        exccode = 5'd4; bd = 1; pc = 32'h3008; #1;
        check("ades_req", {31'd0, int_req}, 32'h1);
        cyc();
        exccode = 0; bd = 0;
        check("ades_epc", epc, 32'h3004);
        a1 = 5'd13; #1;
        check("ades_cause", dout, 32'h8000_0010);
        exl_clr = 1; cyc(); exl_clr = 0;

        // EPC alignment and unmapped register.
        mtc0(5'd14, 32'h3007);
        a1 = 5'd14; #1 check("epc_align", dout, 32'h3004);
        a1 = 5'd20; #1 check("reg20", dout, 32'h0);

        // mtc0 SR is dropped when the same instruction traps.
        exccode = 5'd5; we = 1; a2 = 5'd12; din = 32'h0;
        #1 check("mtc0_exc_req", {31'd0, int_req}, 32'h1);
        cyc();
        we = 0; exccode = 0;
        a1 = 5'd12; #1 check("mtc0_exc_sr", dout, 32'h0000_0403);
        a1 = 5'd13; #1 check("mtc0_exc_cause", dout, 32'h0000_0014);
        exl_clr = 1; cyc(); exl_clr = 0;

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd8);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd5);
        a1 = 5'd9; #1;
        check("tmr_count", dout, 32'd5);
        check("tmr_idle0", {31'd0, int_req}, 32'h0);
        cyc(); check("tmr_idle1", {31'd0, int_req}, 32'h0);
        cyc(); check("tmr_idle2", {31'd0, int_req}, 32'h0);
        cyc(); check("tmr_fire", {31'd0, int_req}, 32'h1);
        check("tmr_count8", dout, 32'd8);
        a1 = 5'd13; #1 check("tmr_cause", dout, 32'h0000_8014);
        cyc();
        mtc0(5'd11, 32'hFFFF_FFFF);
        check("tmr_clear", dout, 32'h0);
        exl_clr = 1; cyc(); exl_clr = 0;
`else
        mtc0(5'd9, 32'd5);
        a1 = 5'd9;  #1 check("notmr_count", dout, 32'h0);
        a1 = 5'd11; #1 check("notmr_cmp", dout, 32'h0);
`endif
        mtc0(5'd12, 32'h0);

        // Asynchronous reset while inside the handler.
        exccode = 5'd3; pc = 32'h3100;
        cyc();
        exccode = 0; a1 = 5'd12; #1;
        check("pre_rst_sr", dout, 32'h0000_0002);
        reset = 0; #1;
        check("mid_rst_int", {31'd0, int_req}, 32'h0);
        check("mid_rst_sr", dout, 32'h0);
        check("mid_rst_epc", epc, 32'h0);
        a1 = 5'd11; #1;
        check("mid_rst_cmp", dout, TIMER ? 32'hFFFF_FFFF : 32'h0);
        cyc();
        reset = 1;

        // Randomized traffic.
        repeat (3000) begin
            logic [31:0] r;
            reset   = ($urandom_range(0, 299) != 0);
            hwint   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            exccode = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            exl_clr = ($urandom_range(0, 7) == 0);
            we      = !exl_clr && ($urandom_range(0, 2) == 0);
            a2      = regs[$urandom_range(0, 7)];
            din     = $urandom;
            if (a2 == 5'd12) begin
                din[1] = ($urandom_range(0, 3) == 0);
                din[0] = ($urandom_range(0, 3) != 0);
            end
            if (a2 == 5'd11 && $urandom_range(0, 1) == 0)
                din = m_count + 32'($urandom_range(1, 12));
            a1 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 7)];
            r  = $urandom;
            pc = r & 32'hFFFF_FFFC;
            bd = 1'($urandom_range(0, 1));
            cyc();
        end

        reset = 1; we = 0; exccode = 0; exl_clr = 0; hwint = 0;
        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
